elc3_cpu: RTL and testbench

- Multicycle 16-bit LC-3-subset processor top level for the DE2 board: datapath (PC, MAR, MDR, IR, NZP, R0–R7, internal 16-bit bus) plus FSM controller.
- Talks to 1M×16 asynchronous external SRAM through the SRAM pins.
- Memory-maps the switches and a hex display register at xFFFF.
- Drives the LEDs and 7-segment displays for debug.

---
 rtl/elc3_cpu.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_elc3_cpu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elc3_cpu.sv
// elc3_cpu: multicycle 16-bit LC-3 subset processor for the DE2 board.
// Datapath (PC, MAR, MDR, IR, NZP, R0-R7) around a single internal bus, an FSM
// controller, an asynchronous SRAM interface, and switch/hex-display I/O at xFFFF.
module elc3_cpu #(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [8:0]  LEDG,
    output logic [17:0] LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic        SRAM_CE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ
);

    localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_WAIT - 1);
    localparam logic [15:0] IoAddr = 16'hFFFF;

    typedef enum logic [7:0] {
        StBr       = 8'd0,
        StAdd      = 8'd1,
        StJsr      = 8'd4,
        StAnd      = 8'd5,
        StLdrAddr  = 8'd6,
        StStrAddr  = 8'd7,
        StNot      = 8'd9,
        StJmp      = 8'd12,
        StLea      = 8'd14,
        StStrWrite = 8'd16,
        StF1       = 8'd18,
        StJsr2     = 8'd21,
        StStrData  = 8'd23,
        StLdrRead  = 8'd25,
        StLdrWb    = 8'd27,
        StDec      = 8'd32,
        StF2       = 8'd33,
        StF3       = 8'd35,
        StHalt     = 8'd64,
        StPause    = 8'd65
    } state_e;

    logic rst_n;
    assign rst_n = KEY[0];

    state_e          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [15:0]     mar_q, mar_d;
    logic [15:0]     mdr_q, mdr_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     hex_q, hex_d;
    logic [2:0]      nzp_q, nzp_d;
    logic [15:0]     reg_q [8];
    logic [15:0]     reg_d [8];
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            pause_seen_q, pause_seen_d;

    // Probe-visible control and register-file read signals.
    logic [7:0]  State;
    logic [3:0]  Opcode;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] SR1;
    logic [15:0] SR2;

    logic [15:0] sr_store;
    logic [2:0]  dr;
    logic [15:0] imm5, off6, off9, off11, alu_b;
    logic [15:0] bus;
    logic        mem_io, mem_read, mem_write, mem_last;
    logic        running;

    assign State    = state_q;
    assign Opcode   = ir_q[15:12];
    assign dr       = ir_q[11:9];
    assign SR1      = reg_q[ir_q[8:6]];
    assign SR2      = reg_q[ir_q[2:0]];
    assign sr_store = reg_q[ir_q[11:9]];

    assign imm5  = {{11{ir_q[4]}}, ir_q[4:0]};
    assign off6  = {{10{ir_q[5]}}, ir_q[5:0]};
    assign off9  = {{7{ir_q[8]}}, ir_q[8:0]};
    assign off11 = {{5{ir_q[10]}}, ir_q[10:0]};
    assign alu_b = ir_q[5] ? imm5 : SR2;

    assign mem_io    = (mar_q == IoAddr);
    assign mem_read  = (state_q == StF2) || (state_q == StLdrRead);
    assign mem_write = (state_q == StStrWrite);
    assign MIO_EN    = mem_read || mem_write;
    assign R_W       = mem_write;
    // The I/O location completes in one cycle; SRAM accesses take MEM_WAIT cycles.
    assign mem_last  = mem_io || (wait_cnt_q == CntLast);

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15]) begin
            return 3'b100;
        end else if (v == 16'h0000) begin
            return 3'b010;
        end
        return 3'b001;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Internal bus: the one value each state may latch into a register.
    always_comb begin
        bus = 16'h0000;
        case (state_q)
            StF1:                 bus = pc_q;
            StF3:                 bus = mdr_q;
            StAdd:                bus = SR1 + alu_b;
            StAnd:                bus = SR1 & alu_b;
            StNot:                bus = ~SR1;
            StBr:                 bus = pc_q + off9;
            StJmp:                bus = SR1;
            StJsr:                bus = pc_q;
            StJsr2:               bus = ir_q[11] ? (pc_q + off11) : SR1;
            StLdrAddr, StStrAddr: bus = SR1 + off6;
            StLdrWb:              bus = mdr_q;
            StStrData:            bus = sr_store;
            StLea:                bus = pc_q + off9;
            default:              bus = 16'h0000;
        endcase
    end

    // Controller next state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mar_d        = mar_q;
        mdr_d        = mdr_q;
        ir_d         = ir_q;
        hex_d        = hex_q;
        nzp_d        = nzp_q;
        reg_d        = reg_q;
        pause_seen_d = pause_seen_q;
        wait_cnt_d   = '0;

        if (MIO_EN && !mem_io && !mem_last) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end

        case (state_q)
            StHalt: begin
                if (!KEY[3]) state_d = StF1;
            end
            StF1: begin
                mar_d   = bus;
                pc_d    = pc_q + 16'd1;
                state_d = StF2;
            end
            StF2, StLdrRead: begin
                if (mem_last) begin
                    mdr_d   = mem_io ? SW[15:0] : SRAM_DQ;
                    state_d = (state_q == StF2) ? StF3 : StLdrWb;
                end
            end
            StF3: begin
                ir_d    = bus;
                state_d = StDec;
            end
            StDec: begin
                case (Opcode)
                    4'b0001: state_d = StAdd;
                    4'b0101: state_d = StAnd;
                    4'b1001: state_d = StNot;
                    4'b0000: state_d = StBr;
                    4'b1100: state_d = StJmp;
                    4'b0100: state_d = StJsr;
                    4'b0110: state_d = StLdrAddr;
                    4'b0111: state_d = StStrAddr;
                    4'b1110: state_d = StLea;
                    4'b1101: state_d = StPause;
                    default: state_d = StF1;
                endcase
            end
            StAdd, StAnd, StNot, StLdrWb: begin
                reg_d[dr] = bus;
                nzp_d     = nzp_of(bus);
                state_d   = StF1;
            end
            StLea: begin
                reg_d[dr] = bus;
                state_d   = StF1;
            end
            StBr: begin
                if ((ir_q[11:9] & nzp_q) != 3'b000) pc_d = bus;
                state_d = StF1;
            end
            StJmp, StJsr2: begin
                pc_d    = bus;
                state_d = StF1;
            end
            StJsr: begin
                reg_d[7] = bus;
                state_d  = StJsr2;
            end
            StLdrAddr: begin
                mar_d   = bus;
                state_d = StLdrRead;
            end
            StStrAddr: begin
                mar_d   = bus;
                state_d = StStrData;
            end
            StStrData: begin
                mdr_d   = bus;
                state_d = StStrWrite;
            end
            StStrWrite: begin
                // MAR/MDR are not rewritten until the end of F1/F2, so address and
                // data stay stable for at least one cycle after WE_N rises.
                if (mem_last) begin
                    if (mem_io) hex_d = mdr_q;
                    state_d = StF1;
                end
            end
            StPause: begin
                // Resume only on a full press-and-release of Continue.
                if (!KEY[2]) begin
                    pause_seen_d = 1'b1;
                end else if (pause_seen_q) begin
                    pause_seen_d = 1'b0;
                    state_d      = StF1;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q      <= StHalt;
            pc_q         <= 16'h0000;
            mar_q        <= 16'h0000;
            mdr_q        <= 16'h0000;
            ir_q         <= 16'h0000;
            hex_q        <= 16'h0000;
            nzp_q        <= 3'b010;
            wait_cnt_q   <= '0;
            pause_seen_q <= 1'b0;
            for (int i = 0; i < 8; i++) reg_q[i] <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            ir_q         <= ir_d;
            hex_q        <= hex_d;
            nzp_q        <= nzp_d;
            wait_cnt_q   <= wait_cnt_d;
            pause_seen_q <= pause_seen_d;
            for (int i = 0; i < 8; i++) reg_q[i] <= reg_d[i];
        end
    end

    assign SRAM_CE_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_OE_N = ~(MIO_EN & ~R_W & ~mem_io);
    assign SRAM_WE_N = ~(R_W & ~mem_io);
    assign SRAM_ADDR = {4'h0, mar_q};
    assign SRAM_DQ   = SRAM_WE_N ? 16'hzzzz : mdr_q;

    assign running = (state_q != StHalt) && (state_q != StPause);
    assign LEDG    = {running, 5'b00000, nzp_q};
    assign LEDR    = {2'b00, ir_q};

    assign HEX0 = seg7(hex_q[3:0]);
    assign HEX1 = seg7(hex_q[7:4]);
    assign HEX2 = seg7(hex_q[11:8]);
    assign HEX3 = seg7(hex_q[15:12]);
    assign HEX4 = seg7(pc_q[3:0]);
    assign HEX5 = seg7(pc_q[7:4]);
    assign HEX6 = seg7(pc_q[11:8]);
    assign HEX7 = seg7(pc_q[15:12]);

    logic unused_ok;
    assign unused_ok = ^{KEY[1], SW[17:16], State};

endmodule

// File: tb/tb_elc3_cpu.sv
// Bench for elc3_cpu: small programs in a behavioural SRAM, memory and hex-register
// writes checked against a scoreboard, architectural state probed after each step.
`timescale 1ns/1ps
module tb_elc3_cpu;

    localparam int MemWait = 3;
    localparam int Budget  = 400;

    logic        clk;
    logic [3:0]  key;
    logic [17:0] sw;
    logic [8:0]  ledg;
    logic [17:0] ledr;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        sram_ce_n, sram_lb_n, sram_ub_n, sram_oe_n, sram_we_n;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;

    elc3_cpu #(.MEM_WAIT(MemWait)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .LEDG     (ledg),
        .LEDR     (ledr),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5),
        .HEX6     (hex6),
        .HEX7     (hex7),
        .SRAM_CE_N(sram_ce_n),
        .SRAM_LB_N(sram_lb_n),
        .SRAM_UB_N(sram_ub_n),
        .SRAM_OE_N(sram_oe_n),
        .SRAM_WE_N(sram_we_n),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ  (sram_dq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: program image from the stimulus, overlaid by words the CPU writes.
    logic [15:0] mem    [256];
    logic [15:0] wmem   [256];
    logic        wvalid [256];
    logic [15:0] rd_word;

    always_comb begin
        rd_word = wvalid[sram_addr[7:0]] ? wmem[sram_addr[7:0]] : mem[sram_addr[7:0]];
    end
    assign sram_dq = (!sram_oe_n && sram_we_n) ? rd_word : 16'hzzzz;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic        io;
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t sb_q[$];

    int          we_low       = 0;
    int          we_low_total = 0;
    int          io_oe_cnt    = 0;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_unstable;
    logic [15:0] prev_hex;
    logic        rst_edge;

    always @(posedge clk) rst_edge <= !key[0];

    // Write monitor: pops the scoreboard on each completed SRAM or hex-register write.
    always @(negedge clk) begin
        wr_t exp_wr;
        if (rst_edge) begin
            we_low   = 0;
            prev_hex = dut.hex_q;
            for (int i = 0; i < 256; i++) wvalid[i] = 1'b0;
        end else begin
            if (!sram_oe_n && sram_addr == 20'h0FFFF) io_oe_cnt++;
            if (!sram_we_n) begin
                if (we_low == 0) begin
                    wr_addr     = sram_addr;
                    wr_data     = sram_dq;
                    wr_unstable = 1'b0;
                end else if (sram_addr !== wr_addr || sram_dq !== wr_data) begin
                    wr_unstable = 1'b1;
                end
                wmem[sram_addr[7:0]]   = sram_dq;
                wvalid[sram_addr[7:0]] = 1'b1;
                we_low++;
                we_low_total++;
            end else if (we_low != 0) begin
                check_eq("wr_addr_hold", 32'(sram_addr), 32'(wr_addr));
                if (sb_q.size() == 0) begin
                    check_eq("wr_sb_pending", 32'(sb_q.size()), 1);
                end else begin
                    exp_wr = sb_q.pop_front();
                    check_eq("wr_is_sram", 32'(exp_wr.io), 0);
                    check_eq("wr_addr", 32'(wr_addr), 32'(exp_wr.addr));
                    check_eq("wr_data", 32'(wr_data), 32'(exp_wr.data));
                    check_eq("wr_we_cycles", 32'(we_low), MemWait);
                    check_eq("wr_stable", 32'(wr_unstable), 0);
                end
                we_low = 0;
            end
            if (dut.hex_q !== prev_hex) begin
                if (sb_q.size() == 0) begin
                    check_eq("hex_sb_pending", 32'(sb_q.size()), 1);
                end else begin
                    exp_wr = sb_q.pop_front();
                    check_eq("hex_is_io", 32'(exp_wr.io), 1);
                    check_eq("hex_data", 32'(dut.hex_q), 32'(exp_wr.data));
                end
                prev_hex = dut.hex_q;
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        key[0] = 1'b0;
        repeat (cycles) @(negedge clk);
        key[0] = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic start_run();
        @(negedge clk);
        key[3] = 1'b0;
        @(negedge clk);
        key[3] = 1'b1;
    endtask

    // Wait for fetch (F1) of the instruction at pc, bounded.
    task automatic wait_fetch(input logic [15:0] pc, input string tag);
        int n = 0;
        while (!(dut.State == 8'd18 && dut.pc_q == pc) && n < Budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n < Budget), 1);
    endtask

    task automatic wait_state(input logic [7:0] st, input string tag);
        int n = 0;
        while (dut.State != st && n < Budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n < Budget), 1);
    endtask

    initial begin
        key = 4'hF;
        sw  = 18'h00000;
        clear_mem();

        // Reset state
        do_reset(2);
        check_eq("rst_state", 32'(dut.State), 64);
        check_eq("rst_pc", 32'(dut.pc_q), 0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("rst_r%0d", i), 32'(dut.reg_q[i]), 0);
        check_eq("rst_nzp", 32'(dut.nzp_q), 32'b010);
        check_eq("rst_we_n", 32'(sram_we_n), 1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 1);
        check_eq("rst_hex", 32'({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}),
                 32'({8{7'b1000000}}));
        check_eq("rst_hex7", 32'(hex7), 32'h40);
        check_eq("rst_hex0", 32'(hex0), 32'h40);
        check_eq("rst_ledg", 32'(ledg), 32'h002);
        check_eq("rst_ledr", 32'(ledr), 0);

        // Program A: switch read, add, store to the hex register, branch loop
        clear_mem();
        mem[0] = 16'h623F;  // LDR R1,R0,#-1
        mem[1] = 16'h1463;  // ADD R2,R1,#3
        mem[2] = 16'h743F;  // STR R2,R0,#-1
        mem[3] = 16'h0FFF;  // BRnzp #-1
        sw = 18'h30005;
        we_low_total = 0;
        io_oe_cnt    = 0;
        sb_q.push_back('{io: 1'b1, addr: 20'h0FFFF, data: 16'h0008});
        start_run();
        wait_fetch(16'd3, "A_fetch3");
        check_eq("A_r1", 32'(dut.reg_q[1]), 5);
        check_eq("A_r2", 32'(dut.reg_q[2]), 8);
        check_eq("A_nzp", 32'(dut.nzp_q), 32'b001);
        check_eq("A_hex0", 32'(hex0), 32'h00);
        check_eq("A_hex1", 32'(hex1), 32'h40);
        check_eq("A_hex4_pc", 32'(hex4), 32'h30);
        check_eq("A_ledg", 32'(ledg), 32'h101);
        check_eq("A_ledr", 32'(ledr), 32'h743F);
        repeat (60) @(negedge clk);
        check_eq("A_br_loop_pc", 32'(dut.pc_q == 16'd3 || dut.pc_q == 16'd4), 1);
        check_eq("A_no_sram_wr", 32'(we_low_total), 0);
        check_eq("A_io_no_oe", 32'(io_oe_cnt), 0);
        check_eq("A_sb_empty", 32'(sb_q.size()), 0);

        // Program B: SRAM store then load back
        do_reset(2);
        clear_mem();
        mem[0] = 16'h1428;  // ADD R2,R0,#8
        mem[1] = 16'h7410;  // STR R2,R0,#16
        mem[2] = 16'h6610;  // LDR R3,R0,#16
        mem[3] = 16'h0FFF;
        we_low_total = 0;
        sb_q.push_back('{io: 1'b0, addr: 20'h00010, data: 16'h0008});
        start_run();
        wait_fetch(16'd3, "B_fetch3");
        check_eq("B_r3", 32'(dut.reg_q[3]), 8);
        check_eq("B_nzp", 32'(dut.nzp_q), 32'b001);
        check_eq("B_we_total", 32'(we_low_total), MemWait);
        check_eq("B_sb_empty", 32'(sb_q.size()), 0);

        // Program C: flags and conditional branches
        do_reset(2);
        clear_mem();
        mem[0] = 16'h1221;  // ADD R1,R0,#1
        mem[1] = 16'h5020;  // AND R0,R0,#0
        mem[2] = 16'h0402;  // BRz #2
        mem[3] = 16'h1261;  // ADD R1,R1,#1 (skipped)
        mem[4] = 16'h1261;  // ADD R1,R1,#1 (skipped)
        mem[5] = 16'h0802;  // BRn #2 (not taken)
        mem[6] = 16'h987F;  // NOT R4,R1
        mem[7] = 16'hEBF8;  // LEA R5,#-8
        mem[8] = 16'h0FFF;
        start_run();
        wait_fetch(16'd5, "C_brz_taken");
        check_eq("C_nzp_z", 32'(dut.nzp_q), 32'b010);
        check_eq("C_r1_skip", 32'(dut.reg_q[1]), 1);
        wait_fetch(16'd6, "C_brn_not_taken");
        wait_fetch(16'd8, "C_fetch8");
        check_eq("C_r4_not", 32'(dut.reg_q[4]), 32'hFFFE);
        check_eq("C_nzp_n", 32'(dut.nzp_q), 32'b100);
        check_eq("C_r5_lea", 32'(dut.reg_q[5]), 0);

        // Program D: JSR/JMP, then PAUSE resume and reset during PAUSE
        do_reset(2);
        clear_mem();
        mem[4]  = 16'h4805;  // JSR #5
        mem[5]  = 16'hD123;  // PAUSE
        mem[6]  = 16'hD123;  // PAUSE
        mem[7]  = 16'h0FFF;
        mem[10] = 16'hC1C0;  // JMP R7
        start_run();
        wait_fetch(16'd10, "D_jsr_target");
        check_eq("D_r7", 32'(dut.reg_q[7]), 5);
        wait_fetch(16'd5, "D_jmp_r7");
        wait_state(8'd65, "D_pause_enter");
        check_eq("D_pause_ledr", 32'(ledr), 32'hD123);
        check_eq("D_pause_ledg8", 32'(ledg[8]), 0);
        check_eq("D_pause_pc", 32'(dut.pc_q), 6);
        key[2] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("D_pause_held", 32'(dut.State), 65);
        key[2] = 1'b1;
        wait_fetch(16'd6, "D_resume");
        wait_state(8'd65, "D_pause2_enter");
        do_reset(1);
        check_eq("D_rst_state", 32'(dut.State), 64);
        check_eq("D_rst_pc", 32'(dut.pc_q), 0);
        check_eq("D_rst_oe_n", 32'(sram_oe_n), 1);
        check_eq("D_sb_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
